// File: rtl/tlb_index_sched.sv
// rtl/tlb_index_sched.sv - CP0 TLB write/probe sequencer holding the Random and Index registers
//
// Optional feature macro: TLB_WIRED_BOUND_EN (defined: Random never steps below Wired;
// undefined: Random cycles ENTRIES-1 down to 0 and wraps, wired_q ignored for bounding).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   adv       in   pipeline advance; Random steps while idle
//   wired_q   in   Wired register value (low IDX_W bits used as bound)
//   wired_we  in   Wired register write; reloads Random
//   index_we  in   MTC0 write strobe for Index
//   index_d   in   MTC0 write data
//   tlbwi     in   TLBWI command pulse
//   tlbwr     in   TLBWR command pulse
//   tlbp      in   TLBP command pulse
//   scan_hit  in   TLB compare result for scan_idx
//   scan_idx  out  entry currently probed
//   tlb_we    out  TLB write strobe
//   tlb_widx  out  TLB write index
//   busy      out  pipeline stall request
//   index_q   out  Index register {P, 0..., idx}
//   random_q  out  Random register, zero-extended
module tlb_index_sched #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [31:0]      wired_q,
  input  logic             wired_we,
  input  logic             index_we,
  input  logic [31:0]      index_d,
  input  logic             tlbwi,
  input  logic             tlbwr,
  input  logic             tlbp,
  input  logic             scan_hit,
  output logic [IDX_W-1:0] scan_idx,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_widx,
  output logic             busy,
  output logic [31:0]      index_q,
  output logic [31:0]      random_q
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, PROBE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] widx_r;
  logic [IDX_W-1:0] k_r;
  logic [IDX_W-1:0] random_r;
  logic [IDX_W-1:0] random_nxt;
  logic [IDX_W-1:0] index_idx_r;
  logic             index_p_r;
  logic             accept_w;
  logic             accept_p;
  logic             probe_hit;
  logic             probe_miss;
  logic             at_floor;
  logic             unused_bits;

  // Only Index[31] and the low index bits are architected; the rest read as zero.
  assign unused_bits = ^{index_d[30:IDX_W], wired_q};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tlb_we     = 1'b0;
    accept_w   = 1'b0;
    accept_p   = 1'b0;
    probe_hit  = 1'b0;
    probe_miss = 1'b0;
    case (state)
      IDLE: begin
        if (tlbp) begin
          accept_p  = 1'b1;
          state_nxt = PROBE;
        end else if (tlbwi || tlbwr) begin
          accept_w  = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        tlb_we    = 1'b1;
        state_nxt = IDLE;
      end
      PROBE: begin
        if (scan_hit) begin
          probe_hit = 1'b1;
          state_nxt = IDLE;
        end else if (k_r == LAST) begin
          probe_miss = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raw command lines stall the accept cycle itself.
  assign busy = (state != IDLE) | tlbwi | tlbwr | tlbp;

`ifdef TLB_WIRED_BOUND_EN
  // A Wired value beyond the table pins Random at the top entry.
  assign at_floor = (|wired_q[31:IDX_W]) || (random_r <= wired_q[IDX_W-1:0]);
`else
  assign at_floor = (random_r == '0);
`endif

  always_comb begin
    random_nxt = random_r;
    if (wired_we) begin
      random_nxt = LAST;
    end else if (adv && state == IDLE) begin
      if (at_floor) random_nxt = LAST;
      else          random_nxt = random_r - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) random_r <= LAST;
    else     random_r <= random_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_r      <= '0;
      k_r         <= '0;
      index_p_r   <= 1'b0;
      index_idx_r <= '0;
    end else begin
      // Register reads here see pre-update values, so a same-cycle MTC0 Index
      // write does not affect the index a TLBWI uses.
      if (accept_w) widx_r <= tlbwi ? index_idx_r : random_r;

      if (accept_p)
        k_r <= '0;
      else if (state == PROBE && !probe_hit && !probe_miss)
        k_r <= k_r + IDX_W'(1);

      if (state == IDLE && index_we) begin
        index_p_r   <= index_d[31];
        index_idx_r <= index_d[IDX_W-1:0];
      end else if (probe_hit) begin
        index_p_r   <= 1'b0;
        index_idx_r <= k_r;
      end else if (probe_miss) begin
        index_p_r   <= 1'b1;
      end
    end
  end

  assign scan_idx = k_r;
  assign tlb_widx = widx_r;
  assign index_q  = {index_p_r, {(31 - IDX_W){1'b0}}, index_idx_r};
  assign random_q = {{(32 - IDX_W){1'b0}}, random_r};

endmodule

// File: tb/tb_tlb_index_sched.sv
// tb/tb_tlb_index_sched.sv - directed self-checking bench for tlb_index_sched
module tb_tlb_index_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adv = 1'b0;
  logic [31:0] wired_q = '0;
  logic        wired_we = 1'b0;
  logic        index_we = 1'b0;
  logic [31:0] index_d = '0;
  logic        tlbwi = 1'b0;
  logic        tlbwr = 1'b0;
  logic        tlbp = 1'b0;
  logic        scan_hit;
  logic [3:0]  scan_idx;
  logic        tlb_we;
  logic [3:0]  tlb_widx;
  logic        busy;
  logic [31:0] index_q;
  logic [31:0] random_q;

  logic        hit_en = 1'b0;
  logic [3:0]  hit_at = '0;

  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  // Responder model of the TLB compare array.
  always_comb scan_hit = hit_en && (scan_idx == hit_at);

  tlb_index_sched #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .adv(adv), .wired_q(wired_q), .wired_we(wired_we),
    .index_we(index_we), .index_d(index_d), .tlbwi(tlbwi), .tlbwr(tlbwr),
    .tlbp(tlbp), .scan_hit(scan_hit), .scan_idx(scan_idx), .tlb_we(tlb_we),
    .tlb_widx(tlb_widx), .busy(busy), .index_q(index_q), .random_q(random_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_random", random_q, 32'd15);
    chk("rst_index", index_q, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", tlb_we, 1'b0);
    chk("rst_scan", scan_idx, 4'd0);
    chk("rst_widx", tlb_widx, 4'd0);

    // Wired = 0: full countdown then wrap
    adv = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick;
      chk("rand_w0", random_q, (i == 16) ? 32'd15 : 32'(15 - i));
    end

    // Wired = 5
    wired_q = 32'd5;
    for (int j = 1; j <= 11; j++) begin
      tick;
`ifdef TLB_WIRED_BOUND_EN
      chk("rand_w5", random_q, (j <= 10) ? 32'(15 - j) : 32'd15);
`else
      chk("rand_w5", random_q, 32'(15 - j));
`endif
    end

    // Wired write reloads; bring Random to 9, then wired_we beats adv
    adv = 1'b0; wired_we = 1'b1;
    tick;
    wired_we = 1'b0;
    chk("wired_reload", random_q, 32'd15);
    adv = 1'b1;
    repeat (6) tick;
    chk("rand_at9", random_q, 32'd9);
    wired_we = 1'b1;
    tick;
    wired_we = 1'b0; adv = 1'b0;
    #1;
    chk("wired_prio", random_q, 32'd15);

    // MTC0 Index then TLBWI
    index_we = 1'b1; index_d = 32'd3;
    tick;
    index_we = 1'b0;
    #1;
    chk("index_wr", index_q, 32'd3);
    tlbwi = 1'b1;
    #1;
    chk("wi_busy_t", busy, 1'b1);
    chk("wi_we_t", tlb_we, 1'b0);
    tick;
    tlbwi = 1'b0;
    #1;
    chk("wi_busy_t1", busy, 1'b1);
    chk("wi_we_t1", tlb_we, 1'b1);
    chk("wi_widx", tlb_widx, 4'd3);
    tick;
    chk("wi_busy_t2", busy, 1'b0);
    chk("wi_we_t2", tlb_we, 1'b0);

    // Same-cycle Index write and TLBWI: command uses old index
    index_we = 1'b1; index_d = 32'hFFFF_FFF7; tlbwi = 1'b1;
    tick;
    index_we = 1'b0; tlbwi = 1'b0;
    #1;
    chk("wi_old_widx", tlb_widx, 4'd3);
    chk("wi_new_index", index_q, 32'h8000_0007);
    tick;

    // TLBWR with Random = 12, Random frozen while busy
    adv = 1'b1;
    repeat (3) tick;
    adv = 1'b0;
    #1;
    chk("rand_at12", random_q, 32'd12);
    tlbwr = 1'b1;
    tick;
    tlbwr = 1'b0; adv = 1'b1;
    #1;
    chk("wr_we", tlb_we, 1'b1);
    chk("wr_widx", tlb_widx, 4'd12);
    chk("wr_rand_t1", random_q, 32'd12);
    tick;
    adv = 1'b0;
    #1;
    chk("wr_rand_frozen", random_q, 32'd12);
    chk("wr_busy_done", busy, 1'b0);

    // Probe hit at 6, all three commands asserted (tlbp wins)
    hit_en = 1'b1; hit_at = 4'd6;
    tlbp = 1'b1; tlbwi = 1'b1; tlbwr = 1'b1;
    #1;
    n = 0;
    while (busy && n < 40) begin
      if (n >= 1) chk("hit_scan", scan_idx, 32'(n - 1));
      chk("hit_no_we", tlb_we, 1'b0);
      tick;
      tlbp = 1'b0; tlbwi = 1'b0; tlbwr = 1'b0;
      #1;
      n++;
    end
    chk("hit_busy_len", n, 32'd8);
    chk("hit_index", index_q, 32'h0000_0006);
    chk("hit_rand", random_q, 32'd12);

    // Probe miss with Index = 2; Index write during scan is ignored
    hit_en = 1'b0;
    index_we = 1'b1; index_d = 32'd2;
    tick;
    index_we = 1'b0;
    #1;
    chk("index_2", index_q, 32'd2);
    tlbp = 1'b1;
    #1;
    n = 0;
    while (busy && n < 40) begin
      if (n >= 1) chk("miss_scan", scan_idx, 32'(n - 1));
      tick;
      tlbp = 1'b0;
      index_we = (n == 2);
      index_d = 32'h55;
      #1;
      n++;
    end
    index_we = 1'b0;
    chk("miss_busy_len", n, 32'd17);
    chk("miss_index", index_q, 32'h8000_0002);

    // Reset at scan index 4 aborts to IDLE without touching Index (Index = 0 here)
    index_we = 1'b1; index_d = 32'd0;
    tick;
    index_we = 1'b0;
    tlbp = 1'b1;
    tick;
    tlbp = 1'b0;
    repeat (4) tick;
    chk("abort_scan4", scan_idx, 4'd4);
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_index", index_q, 32'd0);
    chk("abort_we", tlb_we, 1'b0);
    chk("abort_scan", scan_idx, 4'd0);
    tick;
    chk("abort_idle", busy, 1'b0);
    chk("abort_we2", tlb_we, 1'b0);
    chk("abort_index2", index_q, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlb_index_sched.md
# tlb_index_sched

Sequencer and index generator for the CP0 TLB write and probe path. Holds the Random and Index registers, bounds Random below by the Wired register value, and turns TLBWI, TLBWR and TLBP commands into TLB write strobes or a sequential probe scan. It sits in CP0, between the decode/MEM command lines, the Wired register output and the TLB array ports. It stalls the pipeline through `busy` while a command is in progress.

## Interface
- `ENTRIES`, 16: number of TLB entries (power of two, 4..64).
- `IDX_W`, 4: index width, equal to log2(`ENTRIES`).

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `adv` input 1: pipeline advance; Random steps on cycles where this is high.
- `wired_q` input 32: current Wired register value (low bits significant).
- `wired_we` input 1: Wired register is being written this cycle.
- `index_we` input 1: MTC0 write to Index.
- `index_d` input 32: MTC0 write data.
- `tlbwi` input 1: TLBWI command (one-cycle pulse).
- `tlbwr` input 1: TLBWR command (one-cycle pulse).
- `tlbp` input 1: TLBP command (one-cycle pulse).
- `scan_hit` input 1: combinational TLB compare result for `scan_idx`.
- `scan_idx` output IDX_W: entry under probe.
- `tlb_we` output 1: TLB write strobe.
- `tlb_widx` output IDX_W: TLB write index.
- `busy` output 1: stall request.
- `index_q` output 32: Index register, laid out as {P, 0…, idx}.
- `random_q` output 32: Random register, zero-extended.

## Operation
- FSM states: IDLE, WRITE, PROBE.
- **IDLE**
  - `tlbwi` or `tlbwr`: latch the write index and go to WRITE. The index is `index_q[IDX_W-1:0]` for TLBWI and `random_q[IDX_W-1:0]` for TLBWR, both taken before any same-cycle update.
  - `tlbp`: clear the scan counter and go to PROBE.
  - Command priority when several are asserted: `tlbp` > `tlbwi` > `tlbwr`. Only one command is accepted.
- **WRITE**
  - `tlb_we`=1 and `tlb_widx`=latched index for exactly one cycle.
  - Then return to IDLE.
- **PROBE**
  - `scan_idx` = counter k.
  - `scan_hit`=1: Index ← {1'b0, 0…, k}; go to IDLE.
  - `scan_hit`=0 with k=`ENTRIES`-1: set Index[31]=1, leave low bits unchanged; go to IDLE.
  - Otherwise k increments.
  - First hit wins, so the lowest index is reported.
- **Random**
  - Reset or `wired_we`: Random ← `ENTRIES`-1. `wired_we` has priority over `adv`.
  - `adv`=1 and state IDLE: if Random ≤ bound, Random ← `ENTRIES`-1; else Random ← Random-1.
  - Random is frozen while state is not IDLE.
  - bound = `wired_q[IDX_W-1:0]`. If `wired_q` ≥ `ENTRIES`, Random holds at `ENTRIES`-1.
- **Index**
  - `index_we` in IDLE: Index ← {`index_d`[31], 0…, `index_d[IDX_W-1:0]`}.
  - `index_we` is ignored when not IDLE.
  - A same-cycle `index_we` and command: the write takes effect, and the command uses the old value.
- **Reset values**
  - Random = `ENTRIES`-1, Index = 0, state IDLE.
  - `tlb_we`=0, `busy`=0, `scan_idx`=0, `tlb_widx`=0.
- **Reset mid-command:** the FSM aborts to IDLE. No `tlb_we` is issued and Index is unchanged.

## Timing
- `busy` = (state≠IDLE) | `tlbwi` | `tlbwr` | `tlbp`. It is combinational, so the accept cycle already stalls.
- Write, accepted at T:
  - `tlb_we` high in T+1.
  - `busy` high during T and T+1, low at T+2.
- Probe, accepted at T:
  - Entry k is scanned in cycle T+1+k.
  - A hit at k updates `index_q` visibly at T+2+k, and `busy` drops in that same cycle.
  - A miss gives `busy` low at T+1+`ENTRIES`.
- Commands arriving while not IDLE are ignored. The pipeline holds them under `busy`.

## Configuration
- `TLB_WIRED_BOUND_EN`
  - Defined: Random is bounded below by Wired, as described above.
  - Undefined: `wired_q` is ignored for bounding, and Random cycles over `ENTRIES`-1 down to 0 and wraps. `wired_we` still reloads Random to `ENTRIES`-1.

## Test plan
- Reset, then wired_q=0 with `adv`=1 for 17 cycles → `random_q` reads 15,14,…,0,15.
- wired_q=5 with 12 cycles of `adv` → `random_q` reads 15…5,15. Pulsing `wired_we` while Random=9 → Random=15 on the next cycle.
- `index_we` with `index_d`=3, then `tlbwi` → `busy` high for 2 cycles, and `tlb_we` for one cycle with `tlb_widx`=3.
- Random=12 and `tlbwr` → `tlb_widx`=12, and Random stays 12 while `busy` is high.
- `tlbp` with `scan_hit` high only at idx 6 → `scan_idx` runs 0..6, then `index_q`=0x00000006 and `busy` lasts 8 cycles.
- `tlbp` with no hit and Index=2 → `index_q`=0x80000002 after 16 scan cycles. Asserting `rst` at scan idx 4 → IDLE with Index unchanged.
